// File: rtl/ripple_carry_adder_4bit.sv
// Registered 4-bit ripple-carry adder built from four chained full-adder cells.
// Carry ripples from bit 0 to bit 3; sum and carry-out are captured each clock.

module rca_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module ripple_carry_adder_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;
    logic [3:0] sum_d;
    logic       cout_d;
    logic [3:0] sum_q;
    logic       cout_q;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_stage
        rca_full_adder u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (carry[i]),
            .s_o (sum_d[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_d = carry[4];

    // Reset wins over whatever operands are present at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Directed and exhaustive checks for the registered 4-bit ripple-carry adder.
// Results are sampled 1 time unit after the capturing rising edge.

module tb_ripple_carry_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;

    int checks;
    int failures;

    ripple_carry_adder_4bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(
        input string    tag,
        input logic [4:0] got,
        input logic [4:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {cout,sum}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic apply(
        input logic       r,
        input logic [3:0] va,
        input logic [3:0] vb,
        input logic       vc
    );
        rst = r;
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a   = 4'hf;
        b   = 4'hf;
        cin = 1'b1;

        apply(1'b1, 4'b1111, 4'b1111, 1'b1);
        check_eq("reset_c1", {cout, sum}, 5'b0_0000);
        apply(1'b1, 4'b1111, 4'b1111, 1'b1);
        check_eq("reset_c2", {cout, sum}, 5'b0_0000);

        apply(1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("zero", {cout, sum}, 5'b0_0000);

        apply(1'b0, 4'b1011, 4'b0111, 1'b0);
        check_eq("b2b_18", {cout, sum}, 5'b1_0010);
        apply(1'b0, 4'b1111, 4'b0101, 1'b1);
        check_eq("b2b_21", {cout, sum}, 5'b1_0101);
        apply(1'b0, 4'b1001, 4'b1111, 1'b0);
        check_eq("b2b_24", {cout, sum}, 5'b1_1000);
        apply(1'b0, 4'b1001, 4'b1111, 1'b0);
        check_eq("idle_hold", {cout, sum}, 5'b1_1000);

        apply(1'b0, 4'b1111, 4'b0000, 1'b1);
        check_eq("ripple_f0c", {cout, sum}, 5'b1_0000);
        apply(1'b0, 4'b1111, 4'b1111, 1'b1);
        check_eq("ripple_ffc", {cout, sum}, 5'b1_1111);

        apply(1'b0, 4'b0011, 4'b0100, 1'b0);
        check_eq("stream_7", {cout, sum}, 5'b0_0111);
        apply(1'b1, 4'b1110, 4'b1101, 1'b1);
        check_eq("mid_reset", {cout, sum}, 5'b0_0000);
        apply(1'b0, 4'b0101, 4'b0110, 1'b1);
        check_eq("post_reset_12", {cout, sum}, 5'b0_1100);
        apply(1'b0, 4'b1000, 4'b1000, 1'b0);
        check_eq("post_reset_16", {cout, sum}, 5'b1_0000);

        for (int i = 0; i < 512; i++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            logic       ec;
            logic [4:0] exp;
            ea  = i[8:5];
            eb  = i[4:1];
            ec  = i[0];
            exp = {1'b0, ea} + {1'b0, eb} + {4'b0000, ec};
            apply(1'b0, ea, eb, ec);
            check_eq("exhaustive", {cout, sum}, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
